// File: rtl/operand_seq6.sv
// operand_seq6 - operand sequencer and result holder for the 6-bit compare unit.
//
// Takes operand A and then operand B over one valid/ready input bus, and
// presents them as stable a0/b0 to the combinational compare unit. One cycle
// later it registers the unit's result and holds it on a valid/ready output
// port until the result is consumed. ops_done counts completed output
// handshakes and wraps modulo 256.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               synchronous abort back to LOAD_A (keeps ops_done)
//   in_valid/in_ready   operand handshake; in_data carries A, then B
//   a0, b0              registered operands driven to the compare unit
//   res_in              compare-unit result (combinational in a0/b0)
//   out_valid/out_ready result handshake; out_data is the registered result
//   ops_done            wrapping count of completed result handshakes
module operand_seq6 #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] a0,
  output logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] res_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [7:0]       ops_done
);

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    EVAL,
    HOLD
  } state_t;

  state_t state, state_nxt;
  logic   in_fire;
  logic   out_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD_A;
    end else begin
      state <= state_nxt;
    end
  end

  // in_ready comes from the state alone so the upstream source never sees a
  // combinational path from its own in_valid.
  always_comb begin
    state_nxt = state;
    in_ready  = (state == LOAD_A) || (state == LOAD_B);
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready && (state == HOLD);
    if (clear) begin
      state_nxt = LOAD_A;
    end else begin
      case (state)
        LOAD_A:  if (in_fire)  state_nxt = LOAD_B;
        LOAD_B:  if (in_fire)  state_nxt = EVAL;
        EVAL:                  state_nxt = HOLD;
        HOLD:    if (out_fire) state_nxt = LOAD_A;
        default:               state_nxt = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0        <= '0;
      b0        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      ops_done  <= '0;
    end else if (clear) begin
      // clear wins over any handshake in the same cycle, so a coinciding
      // result handshake is not counted.
      a0        <= '0;
      b0        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        LOAD_A: if (in_fire) a0 <= in_data;
        LOAD_B: if (in_fire) b0 <= in_data;
        EVAL: begin
          out_data  <= res_in;
          out_valid <= 1'b1;
        end
        HOLD: if (out_fire) begin
          out_valid <= 1'b0;
          ops_done  <= ops_done + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_seq6.sv
// tb_operand_seq6 - self-checking bench for operand_seq6.
//
// The compare unit is modelled here as res_in = ~a0 & b0. Expected results are
// computed from the operands the bench sends, and the expected counter is a
// plain integer count of completed operations taken modulo 256.
module tb_operand_seq6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] in_data = '0;
  logic [5:0] a0, b0;
  logic [5:0] res_in;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [5:0] out_data;
  logic [7:0] ops_done;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cnt = 0;

  operand_seq6 #(.WIDTH(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .a0        (a0),
    .b0        (b0),
    .res_in    (res_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ops_done  (ops_done)
  );

  assign res_in = ~a0 & b0;

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_a0"}, 32'(a0), 32'h0);
    chk({tag, "_b0"}, 32'(b0), 32'h0);
    chk({tag, "_out_data"}, 32'(out_data), 32'h0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'h1);
  endtask

  // Offer one operand after 'idle' cycles with in_valid low; returns at the
  // falling edge following the accepting rising edge.
  task automatic send(input logic [5:0] d, input int unsigned idle);
    bit ok;
    in_valid = 1'b0;
    for (int i = 0; i < int'(idle); i++) begin
      in_data = 6'($urandom);
      @(negedge clk);
      chk("in_ready_idle", 32'(in_ready), 32'h1);
    end
    in_valid = 1'b1;
    in_data  = d;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (in_ready) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("send_timeout", 32'h0, 32'h1);
    in_valid = 1'b0;
  endtask

  // One complete operation: A, B, result check, 'bp' cycles of backpressure
  // with in_valid asserted, then the result handshake.
  task automatic do_op(input logic [5:0] a, input logic [5:0] b,
                       input int unsigned idle, input int unsigned bp);
    logic [5:0] expv;
    expv = ~a & b;
    send(a, idle);
    chk("a0_capture", 32'(a0), 32'(a));
    chk("in_ready_load_b", 32'(in_ready), 32'h1);
    send(b, idle);
    chk("b0_capture", 32'(b0), 32'(b));
    chk("a0_held_eval", 32'(a0), 32'(a));
    chk("in_ready_eval", 32'(in_ready), 32'h0);
    chk("out_valid_eval", 32'(out_valid), 32'h0);
    in_valid  = 1'b1;
    in_data   = 6'($urandom);
    out_ready = 1'b0;
    @(negedge clk);
    chk("out_valid_latency", 32'(out_valid), 32'h1);
    chk("out_data", 32'(out_data), 32'(expv));
    for (int i = 0; i < int'(bp); i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      chk("bp_out_valid", 32'(out_valid), 32'h1);
      chk("bp_out_data", 32'(out_data), 32'(expv));
      chk("bp_a0", 32'(a0), 32'(a));
      chk("bp_b0", 32'(b0), 32'(b));
      chk("bp_ops_done", 32'(ops_done), cnt % 256);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    cnt++;
    chk("ops_done", 32'(ops_done), cnt % 256);
    chk("out_valid_after", 32'(out_valid), 32'h0);
    chk("in_ready_after", 32'(in_ready), 32'h1);
  endtask

  initial begin
    // Reset state
    #2;
    chk_reset_vals("reset");
    chk("reset_ops_done", 32'(ops_done), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic operation and extremes
    do_op(6'b101010, 6'b110011, 0, 0);
    chk("basic_ops_done_one", 32'(ops_done), 32'h1);
    do_op(6'h3F, 6'h00, 0, 0);
    do_op(6'h00, 6'h3F, 1, 0);

    // Backpressure for 5 cycles with in_valid asserted
    do_op(6'h15, 6'h2E, 0, 5);

    // Clear in LOAD_B, with a pending operand
    send(6'h2A, 0);
    in_valid = 1'b1;
    in_data  = 6'h11;
    clear    = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    chk_reset_vals("clr_load_b");
    chk("clr_load_b_ops_done", 32'(ops_done), cnt % 256);
    // Back in LOAD_A: the next operand is taken as A
    do_op(6'h0F, 6'h33, 0, 0);

    // Clear coinciding with the result handshake in HOLD
    send(6'h01, 0);
    send(6'h3E, 0);
    @(negedge clk);
    chk("clr_hold_valid_before", 32'(out_valid), 32'h1);
    clear     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    clear     = 1'b0;
    out_ready = 1'b0;
    chk_reset_vals("clr_hold");
    chk("clr_hold_ops_done", 32'(ops_done), cnt % 256);
    do_op(6'h22, 6'h3C, 0, 1);

    // Asynchronous reset in the middle of EVAL
    send(6'h05, 0);
    send(6'h3A, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    chk("async_reset_ops_done", 32'(ops_done), 32'h0);
    cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(6'h24, 6'h1B, 0, 0);

    // 256 random operations with random duty; ops_done wraps through 0
    for (int k = 0; k < 256; k++) begin
      do_op(6'($urandom), 6'($urandom), $urandom_range(2), $urandom_range(3));
    end
    chk("wrap_ops_done", 32'(ops_done), 32'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_seq6.md
# operand_seq6

Operand sequencer and result holder that sits directly upstream of the 6-bit bitwise compare units in the Mini-ALU. It accepts operand A and then operand B over a shared 6-bit valid/ready input bus. It drives both operands as stable `a0`/`b0` to the compare unit and samples that unit's 6-bit result one cycle later. The result is held on a valid/ready output port until it is consumed. A wrapping 8-bit counter records completed operations.

## Interface
- `WIDTH`, 6, operand and result width. All data ports use it.
- `clk`  in  1  single clock. All state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous abort. Returns the block to LOAD_A.
- `in_valid`  in  1  `in_data` holds an operand.
- `in_ready`  out  1  block can accept an operand this cycle.
- `in_data`  in  WIDTH  operand: A first, then B.
- `a0`  out  WIDTH  registered operand A, driven to the compare unit.
- `b0`  out  WIDTH  registered operand B, driven to the compare unit.
- `res_in`  in  WIDTH  compare-unit result, a combinational function of `a0`/`b0`.
- `out_valid`  out  1  `out_data` holds a result.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  WIDTH  registered result.
- `ops_done`  out  8  count of completed output handshakes. Wraps from 255 to 0.

## Operation
- There are four states: LOAD_A, LOAD_B, EVAL and HOLD.
- LOAD_A:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: `a0` <= `in_data`, then go to LOAD_B.
- LOAD_B:
  - `in_ready`=1.
  - On the handshake: `b0` <= `in_data`, then go to EVAL.
  - `a0` holds its value.
- EVAL:
  - `in_ready`=0.
  - Lasts exactly one cycle.
  - At the end of the cycle: `out_data` <= `res_in` and `out_valid` <= 1, then go to HOLD.
- HOLD:
  - `in_ready`=0, `out_valid`=1.
  - `out_data`, `a0` and `b0` are all stable.
  - On `out_valid`&`out_ready`: `out_valid` <= 0, `ops_done` increments by 1 (mod 256), then go to LOAD_A.
- `in_ready` is decoded from the state only. It must never depend on `in_valid`.
- `out_valid` is a registered output.
- `in_valid` deasserted in a LOAD state: wait with no change.
- `out_ready` deasserted in HOLD: wait indefinitely with no change.
- `clear`:
  - Highest priority; it overrides every handshake in the same cycle.
  - Next state is LOAD_A. `a0`, `b0`, `out_data` and `out_valid` go to 0.
  - `ops_done` is preserved.
  - A HOLD handshake coinciding with `clear` does not count.
- Reset value of every output:
  - `a0`, `b0`, `out_data` = 0.
  - `out_valid` = 0.
  - `ops_done` = 0.
  - State is LOAD_A, so `in_ready` = 1.
  - No capture occurs while `rst_n` is low.
- Reset mid-operation: abandons any partial operand or held result immediately. No counter increment.

## Timing
- Operand A is accepted at edge t0. Operand B is accepted at the earliest at edge t0+1.
- If B is accepted at edge t: `out_valid`=1 and `out_data`=result from after edge t+1.
  - Minimum latency from B handshake to result valid: 1 cycle.
- With `out_ready` held at 1, the handshake happens at edge t+2 and `in_ready` is 1 again after t+2.
- Back-to-back throughput: one operation per 4 cycles.
- The compare unit's combinational path (`a0`/`b0` to `res_in`) must settle within one cycle.
- `a0` and `b0` never change during EVAL or HOLD.

## Test plan
- Basic operation:
  - Stimulus: after reset, send A=6'b101010 then B=6'b110011 with the compare unit attached; `out_ready`=1.
  - Response: `out_valid` rises 1 cycle after the B handshake with `out_data`=6'b010001; `ops_done`=1 after the handshake.
- Extremes:
  - Stimulus: A=6'h3F, B=6'h00.
  - Response: `out_data`=6'h00.
  - Stimulus: A=6'h00, B=6'h3F.
  - Response: `out_data`=6'h3F.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 5 cycles in HOLD while `in_valid`=1.
  - Response: `in_ready` stays 0; `out_data`, `a0` and `b0` stay stable; `ops_done` is unchanged until `out_ready` rises.
- Clear:
  - Stimulus: assert `clear` in LOAD_B; separately, assert it together with `out_ready` in HOLD.
  - Response: the state returns to LOAD_A; `a0`, `b0` and `out_data` read 0; `ops_done` does not increment.
- Asynchronous reset:
  - Stimulus: drop `rst_n` mid-cycle during EVAL.
  - Response: all outputs go to their reset values immediately, without waiting for a clock edge; the next A accepted after release is captured normally.
- Counter wrap:
  - Stimulus: run 256 operations with random operands and a random `in_valid`/`out_ready` duty.
  - Response: every `out_data` equals `~A & B`; `ops_done` wraps from 255 to 0.
